// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between an
// instruction-fetch port (read-only) and a data port (read/write).
module mem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int READ_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_ack_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic          dm_ack_o,
    output logic [DW-1:0] dm_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_we_o,
    output logic          mem_re_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          grant_dm_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    // Counter holds the number of extra WAIT cycles still to spend after this one.
    localparam int WAIT_INIT = (READ_LAT > 1) ? READ_LAT - 2 : 0;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          grant_dm_q, grant_dm_d;
    logic          last_q, last_d;
    logic          rd_q, rd_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          issue;
    logic          win_dm;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_dm_d  = grant_dm_q;
        last_d      = last_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        issue       = 1'b0;
        win_dm      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req_i || dm_req_i) begin
                    issue  = 1'b1;
                    win_dm = dm_req_i && (!if_req_i || !last_q);
                end
            end
            S_ACCESS: begin
                if (READ_LAT > 1) begin
                    state_d = S_WAIT;
                    cnt_d   = 2'(WAIT_INIT);
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_RESP: begin
                // The just-acked requester still holds req this edge; only the other port may chain.
                last_d  = grant_dm_q;
                state_d = S_IDLE;
                if (grant_dm_q ? if_req_i : dm_req_i) begin
                    issue  = 1'b1;
                    win_dm = !grant_dm_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            state_d     = S_ACCESS;
            grant_dm_d  = win_dm;
            mem_addr_d  = win_dm ? dm_addr_i : if_addr_i;
            mem_wdata_d = win_dm ? dm_wdata_i : '0;
            mem_we_d    = win_dm && dm_we_i;
            mem_re_d    = !(win_dm && dm_we_i);
            rd_d        = !(win_dm && dm_we_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            grant_dm_q  <= 1'b0;
            last_q      <= 1'b0;
            rd_q        <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_dm_q  <= grant_dm_d;
            last_q      <= last_d;
            rd_q        <= rd_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_ack_o    = (state_q == S_RESP) && !grant_dm_q;
    assign dm_ack_o    = (state_q == S_RESP) && grant_dm_q;
    assign if_rdata_o  = if_ack_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = (dm_ack_o && rd_q) ? mem_rdata_i : '0;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;
    assign grant_dm_o  = grant_dm_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses READ_LAT=1, instance 1 uses READ_LAT=3,
// each attached to its own behavioural synchronous memory.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        if_req   [2];
    logic [15:0] if_addr  [2];
    logic        if_ack   [2];
    logic [15:0] if_rdata [2];
    logic        dm_req   [2];
    logic        dm_we    [2];
    logic [15:0] dm_addr  [2];
    logic [15:0] dm_wdata [2];
    logic        dm_ack   [2];
    logic [15:0] dm_rdata [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_wdata[2];
    logic        mem_we   [2];
    logic        mem_re   [2];
    logic [15:0] mem_rdata[2];
    logic        grant_dm [2];
    logic        busy     [2];

    int n_cmp = 0;
    int n_err = 0;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            mem_port_arbiter #(.AW(16), .DW(16), .READ_LAT(g == 0 ? 1 : 3)) u_dut (
                .clk_i(clk), .rst_i(rst),
                .if_req_i(if_req[g]), .if_addr_i(if_addr[g]),
                .if_ack_o(if_ack[g]), .if_rdata_o(if_rdata[g]),
                .dm_req_i(dm_req[g]), .dm_we_i(dm_we[g]), .dm_addr_i(dm_addr[g]),
                .dm_wdata_i(dm_wdata[g]), .dm_ack_o(dm_ack[g]), .dm_rdata_o(dm_rdata[g]),
                .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]),
                .mem_we_o(mem_we[g]), .mem_re_o(mem_re[g]), .mem_rdata_i(mem_rdata[g]),
                .grant_dm_o(grant_dm[g]), .busy_o(busy[g])
            );
        end
    endgenerate

    // Memory: write on the edge, read data appears READ_LAT edges after the mem_re edge.
    logic [15:0] mem_arr [2][65536];
    logic [15:0] pipe    [2][3];
    logic        bd_we   [2];
    logic [15:0] bd_addr [2];
    logic [15:0] bd_data [2];

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (bd_we[g])       mem_arr[g][bd_addr[g]] <= bd_data[g];
            else if (mem_we[g]) mem_arr[g][mem_addr[g]] <= mem_wdata[g];
            pipe[g][0] <= mem_re[g] ? mem_arr[g][mem_addr[g]] : 16'hDEAD;
            pipe[g][1] <= pipe[g][0];
            pipe[g][2] <= pipe[g][1];
        end
    end
    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    logic [15:0] ref_mem [16];
    logic        if_done;
    logic        dm_done;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input int k, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bd_we[k] = 1'b1; bd_addr[k] = a; bd_data[k] = d;
        @(negedge clk);
        bd_we[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; dm_req[k] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int k);
        for (int c = 0; c < 30; c++) begin
            if (!if_req[k] && !dm_req[k] && !busy[k]) break;
            tick();
            if (if_ack[k]) if_req[k] = 1'b0;
            if (dm_ack[k]) dm_req[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({busy[k], if_ack[k], dm_ack[k], mem_we[k], mem_re[k], grant_dm[k]} !== 6'b0) begin
                n_err++; $display("FAIL reset_ctl[%0d]: got %b exp 000000", k,
                    {busy[k], if_ack[k], dm_ack[k], mem_we[k], mem_re[k], grant_dm[k]});
            end
            n_cmp++;
            if ({mem_addr[k], mem_wdata[k], if_rdata[k], dm_rdata[k]} !== 64'h0) begin
                n_err++; $display("FAIL reset_data[%0d]: got %h exp 0", k,
                    {mem_addr[k], mem_wdata[k], if_rdata[k], dm_rdata[k]});
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic seen;
        poke(0, 16'h0010, 16'h0000);
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 16'h0010; dm_wdata[0] = 16'hBEEF;
        tick();
        n_cmp++;
        if (mem_we[0] !== 1'b1) begin n_err++; $display("FAIL rst_mid_we_before: got %b exp 1", mem_we[0]); end
        #1 rst = 1'b1;
        dm_req[0] = 1'b0;
        #1;
        n_cmp++;
        if ({mem_we[0], busy[0], dm_ack[0]} !== 3'b000) begin
            n_err++; $display("FAIL rst_mid_async: we/busy/ack got %b exp 000", {mem_we[0], busy[0], dm_ack[0]});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (3) begin tick(); seen = seen | dm_ack[0]; end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_ack: got ack %b exp 0", seen); end
        n_cmp++;
        if (mem_arr[0][16'h0010] !== 16'h0000) begin
            n_err++; $display("FAIL rst_mid_nowrite: got %h exp 0000", mem_arr[0][16'h0010]);
        end
        if_req[0] = 1'b1; if_addr[0] = 16'h0000;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 16'h0010;
        tick();
        n_cmp++;
        if (grant_dm[0] !== 1'b1) begin n_err++; $display("FAIL rst_mid_first_tie: grant got %b exp 1", grant_dm[0]); end
        drain(0);
        n_cmp++;
        if (busy[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_drain: busy got %b exp 0", busy[0]); end
    endtask

    task automatic test_single_if_read();
        poke(0, 16'h0004, 16'h1234);
        if_req[0] = 1'b1; if_addr[0] = 16'h0004;
        tick();
        n_cmp++;
        if ({mem_re[0], mem_we[0], busy[0], grant_dm[0], if_ack[0], mem_addr[0]} !== {5'b10100, 16'h0004}) begin
            n_err++; $display("FAIL if_read_issue: re/we/busy/gnt/ack/addr got %b %h exp 10100 0004",
                {mem_re[0], mem_we[0], busy[0], grant_dm[0], if_ack[0]}, mem_addr[0]);
        end
        tick();
        n_cmp++;
        if ({if_ack[0], dm_ack[0], mem_re[0], if_rdata[0]} !== {3'b100, 16'h1234}) begin
            n_err++; $display("FAIL if_read_ack: ack/dmack/re/rdata got %b %h exp 100 1234",
                {if_ack[0], dm_ack[0], mem_re[0]}, if_rdata[0]);
        end
        if_req[0] = 1'b0;
        tick();
        n_cmp++;
        if ({busy[0], if_ack[0]} !== 2'b00) begin
            n_err++; $display("FAIL if_read_idle: busy/ack got %b exp 00", {busy[0], if_ack[0]});
        end
    endtask

    task automatic test_tie();
        do_reset();
        poke(0, 16'h0000, 16'h7777);
        if_req[0] = 1'b1; if_addr[0] = 16'h0000;
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 16'h0999; dm_wdata[0] = 16'h00AA;
        tick();
        n_cmp++;
        if ({grant_dm[0], mem_we[0], mem_re[0], mem_addr[0], mem_wdata[0]} !== {3'b110, 16'h0999, 16'h00AA}) begin
            n_err++; $display("FAIL tie_dm_first: gnt/we/re addr wdata got %b %h %h exp 110 0999 00aa",
                {grant_dm[0], mem_we[0], mem_re[0]}, mem_addr[0], mem_wdata[0]);
        end
        tick();
        n_cmp++;
        if ({dm_ack[0], if_ack[0], dm_rdata[0]} !== {2'b10, 16'h0000}) begin
            n_err++; $display("FAIL tie_dm_ack: dm/if ack rdata got %b %h exp 10 0000",
                {dm_ack[0], if_ack[0]}, dm_rdata[0]);
        end
        dm_req[0] = 1'b0;
        tick();
        n_cmp++;
        if ({busy[0], grant_dm[0], mem_re[0], if_ack[0], dm_ack[0], mem_addr[0]} !== {5'b10100, 16'h0000}) begin
            n_err++; $display("FAIL tie_if_chain: busy/gnt/re/ifack/dmack addr got %b %h exp 10100 0000",
                {busy[0], grant_dm[0], mem_re[0], if_ack[0], dm_ack[0]}, mem_addr[0]);
        end
        tick();
        n_cmp++;
        if ({if_ack[0], dm_ack[0], if_rdata[0]} !== {2'b10, 16'h7777}) begin
            n_err++; $display("FAIL tie_if_ack: if/dm ack rdata got %b %h exp 10 7777",
                {if_ack[0], dm_ack[0]}, if_rdata[0]);
        end
        n_cmp++;
        if (mem_arr[0][16'h0999] !== 16'h00AA) begin
            n_err++; $display("FAIL tie_mem_write: got %h exp 00aa", mem_arr[0][16'h0999]);
        end
        if_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        int seq [6];
        int n;
        do_reset();
        if_req[0] = 1'b1; if_addr[0] = 16'h0100;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 16'h0200;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            if (if_ack[0] || dm_ack[0]) begin
                seq[n] = dm_ack[0] ? 1 : 0;
                n++;
            end
        end
        if_req[0] = 1'b0; dm_req[0] = 1'b0;
        n_cmp++;
        if (n !== 6) begin n_err++; $display("FAIL fair_count: got %0d acks exp 6", n); end
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (seq[i] !== ((i % 2 == 0) ? 1 : 0)) begin
                n_err++; $display("FAIL fair_seq[%0d]: grant got %0d exp %0d", i, seq[i], (i % 2 == 0) ? 1 : 0);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_full_range();
        int n;
        poke(1, 16'hFFFF, 16'hCAFE);
        dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 16'hFFFF;
        tick();
        n_cmp++;
        if ({mem_re[1], grant_dm[1], mem_addr[1]} !== {2'b11, 16'hFFFF}) begin
            n_err++; $display("FAIL full_issue: re/gnt addr got %b %h exp 11 ffff", {mem_re[1], grant_dm[1]}, mem_addr[1]);
        end
        n = 1;
        for (int c = 0; c < 10 && !dm_ack[1]; c++) begin tick(); n++; end
        n_cmp++;
        if (n !== 4) begin n_err++; $display("FAIL full_latency: ack after %0d edges exp 4", n); end
        n_cmp++;
        if ({dm_ack[1], dm_rdata[1], mem_addr[1]} !== {1'b1, 16'hCAFE, 16'hFFFF}) begin
            n_err++; $display("FAIL full_data: ack rdata addr got %b %h %h exp 1 cafe ffff",
                dm_ack[1], dm_rdata[1], mem_addr[1]);
        end
        dm_req[1] = 1'b0;
        tick();
        n_cmp++;
        if (busy[1] !== 1'b0) begin n_err++; $display("FAIL full_idle: busy got %b exp 0", busy[1]); end
    endtask

    task automatic test_back_to_back();
        int n;
        dm_req[1] = 1'b1; dm_we[1] = 1'b1; dm_addr[1] = 16'hFFFE; dm_wdata[1] = 16'h5A5A;
        n = 0;
        for (int c = 0; c < 10 && !dm_ack[1]; c++) begin tick(); n++; end
        n_cmp++;
        if ({n[3:0], dm_rdata[1]} !== {4'd4, 16'h0000}) begin
            n_err++; $display("FAIL b2b_write_ack: edges %0d rdata %h exp 4 0000", n, dm_rdata[1]);
        end
        dm_we[1] = 1'b0;
        tick();
        n_cmp++;
        if ({busy[1], mem_re[1], mem_we[1]} !== 3'b000) begin
            n_err++; $display("FAIL b2b_idle_gap: busy/re/we got %b exp 000", {busy[1], mem_re[1], mem_we[1]});
        end
        tick();
        n_cmp++;
        if ({busy[1], mem_re[1], mem_addr[1]} !== {2'b11, 16'hFFFE}) begin
            n_err++; $display("FAIL b2b_read_issue: busy/re addr got %b %h exp 11 fffe", {busy[1], mem_re[1]}, mem_addr[1]);
        end
        n = 0;
        for (int c = 0; c < 10 && !dm_ack[1]; c++) begin tick(); n++; end
        n_cmp++;
        if ({n[3:0], dm_rdata[1]} !== {4'd3, 16'h5A5A}) begin
            n_err++; $display("FAIL b2b_read_ack: edges %0d rdata %h exp 3 5a5a", n, dm_rdata[1]);
        end
        dm_req[1] = 1'b0;
        tick();
    endtask

    task automatic rand_if(input int k);
        int gap;
        int got;
        logic [15:0] a;
        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin if_req[k] = 1'b0; repeat (gap) @(negedge clk); end
            a = 16'($urandom_range(0, 15));
            if_addr[k] = a; if_req[k] = 1'b1;
            got = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (if_ack[k]) begin got = 1; break; end
            end
            n_cmp++;
            if (got == 0) begin
                n_err++; $display("FAIL rand_if_timeout[%0d]: no ack after 60 cycles exp ack", k);
            end else if (if_rdata[k] !== ref_mem[a[3:0]]) begin
                n_err++; $display("FAIL rand_if_data[%0d] @%h: got %h exp %h", k, a, if_rdata[k], ref_mem[a[3:0]]);
            end
        end
        if_req[k] = 1'b0;
        if_done = 1'b1;
    endtask

    task automatic rand_dm(input int k);
        int gap;
        int got;
        logic        we;
        logic [15:0] a, d, exp_d;
        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin dm_req[k] = 1'b0; repeat (gap) @(negedge clk); end
            a  = 16'($urandom_range(0, 15));
            d  = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            dm_addr[k] = a; dm_wdata[k] = d; dm_we[k] = we; dm_req[k] = 1'b1;
            got = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (dm_ack[k]) begin got = 1; break; end
            end
            exp_d = we ? 16'h0000 : ref_mem[a[3:0]];
            n_cmp++;
            if (got == 0) begin
                n_err++; $display("FAIL rand_dm_timeout[%0d]: no ack after 60 cycles exp ack", k);
            end else if (dm_rdata[k] !== exp_d) begin
                n_err++; $display("FAIL rand_dm_data[%0d] @%h we=%b: got %h exp %h", k, a, we, dm_rdata[k], exp_d);
            end
            if (we) ref_mem[a[3:0]] = d;
        end
        dm_req[k] = 1'b0;
        dm_done = 1'b1;
    endtask

    // If the other port is requesting at the edge after an ack, it must be served next.
    task automatic rand_mon(input int k);
        int exp_next;
        int last_p;
        int p;
        exp_next = -1;
        last_p   = -1;
        for (int c = 0; c < 4000 && !(if_done && dm_done); c++) begin
            @(posedge clk);
            #1;
            if (last_p >= 0) begin
                exp_next = ((last_p == 1) ? if_req[k] : dm_req[k]) ? 1 - last_p : -1;
                last_p   = -1;
            end
            n_cmp++;
            if (if_ack[k] && dm_ack[k]) begin n_err++; $display("FAIL rand_dual_ack[%0d]: both acks high exp one", k); end
            n_cmp++;
            if (mem_we[k] && mem_re[k]) begin n_err++; $display("FAIL rand_we_re[%0d]: both high exp one", k); end
            n_cmp++;
            if (mem_we[k] && !grant_dm[k]) begin n_err++; $display("FAIL rand_if_write[%0d]: mem_we with IF grant exp none", k); end
            if (if_ack[k] || dm_ack[k]) begin
                p = dm_ack[k] ? 1 : 0;
                if (exp_next >= 0) begin
                    n_cmp++;
                    if (p !== exp_next) begin
                        n_err++; $display("FAIL rand_rr[%0d]: served port %0d exp %0d", k, p, exp_next);
                    end
                end
                exp_next = -1;
                last_p   = p;
            end
        end
        n_cmp++;
        if (!(if_done && dm_done)) begin n_err++; $display("FAIL rand_done[%0d]: requesters unfinished exp finished", k); end
    endtask

    task automatic test_random(input int k);
        logic [15:0] v;
        for (int a = 0; a < 16; a++) begin
            v = 16'($urandom);
            ref_mem[a] = v;
            poke(k, 16'(a), v);
        end
        if_done = 1'b0;
        dm_done = 1'b0;
        fork
            rand_if(k);
            rand_dm(k);
            rand_mon(k);
        join
        drain(k);
        repeat (2) tick();
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0;
            bd_we[k] = 1'b0; bd_addr[k] = '0; bd_data[k] = '0;
        end
        if_done = 1'b0;
        dm_done = 1'b0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_reset_mid_access();
        test_single_if_read();
        test_tie();
        test_fairness();
        test_full_range();
        test_back_to_back();
        test_random(0);
        test_random(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached exp completion");
        $fatal(1, "watchdog");
    end

endmodule
